// File: rtl/rx_char_fifo.sv
`timescale 1ns/1ps
// rx_char_fifo: sanitising FWFT character FIFO (rxuart -> Morse engine)
// that also raises XON/XOFF flow bytes toward the txuart path.
// Ports: clk_24, rst_n (async, active-low)
//   write : i_wr, i_data[7:0]
//   read  : i_rd, o_data[6:0], o_valid
//   status: o_full, o_level[ADDR_W:0], o_drop_cnt[7:0]
//   flow  : i_tx_busy, o_flow_wr, o_flow_data[7:0]
module rx_char_fifo #(
  parameter int ADDR_W     = 11,
  parameter int XOFF_LEVEL = 2016,
  parameter int XON_LEVEL  = 512
) (
  input  logic            clk_24,
  input  logic            rst_n,
  input  logic            i_wr,
  input  logic [7:0]      i_data,
  input  logic            i_rd,
  output logic [6:0]      o_data,
  output logic            o_valid,
  output logic            o_full,
  output logic [ADDR_W:0] o_level,
  output logic [7:0]      o_drop_cnt,
  input  logic            i_tx_busy,
  output logic            o_flow_wr,
  output logic [7:0]      o_flow_data
);

  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] XOFF_L = (ADDR_W+1)'(XOFF_LEVEL);
  localparam logic [ADDR_W:0] XON_L  = (ADDR_W+1)'(XON_LEVEL);
  localparam logic [7:0]      XOFF_B = 8'h13;
  localparam logic [7:0]      XON_B  = 8'h11;

  typedef enum logic {
    FLOW_ON,
    FLOW_OFF
  } flow_t;

  logic [6:0]        r_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_level;
  logic              r_valid;
  logic [6:0]        r_data;
  logic [7:0]        r_drop;

  logic              w_ok;
  logic [6:0]        w_chr;
  logic              w_wr_acc;
  logic              w_drop;
  logic              w_pop;
  logic              w_load;
  logic [ADDR_W:0]   w_ram_cnt;

  flow_t             r_fstate;
  flow_t             w_fstate_nx;
  logic              r_pend;
  logic              w_pend_nx;
  logic [7:0]        r_pbyte;
  logic [7:0]        w_pbyte_nx;
  logic              r_fwr;
  logic              w_fwr_nx;
  logic [7:0]        r_fdata;
  logic [7:0]        w_fdata_nx;

  // Byte sanitiser: items are mutually exclusive (CR/LF are
  // carved out of the control-character discard).
  always_comb begin
    w_ok  = 1'b1;
    w_chr = i_data[6:0];
    unique case (1'b1)
      i_data[7]:
        w_ok = 1'b0;
      (i_data >= 8'h61 && i_data <= 8'h7A):
        w_chr = i_data[6:0] - 7'h20;
      (i_data == 8'h0D || i_data == 8'h0A):
        w_chr = 7'h20;
      ((i_data < 8'h20 && i_data != 8'h0D
        && i_data != 8'h0A) || i_data == 8'h7F):
        w_ok = 1'b0;
      default: ;
    endcase
  end

  assign o_full   = (r_level == DEPTH);
  assign w_wr_acc = i_wr & w_ok & ~o_full;
  assign w_drop   = i_wr & w_ok & o_full;
  assign w_pop    = i_rd & r_valid;

  // Entries still in RAM, i.e. not yet in the output register.
  assign w_ram_cnt = r_level - {{ADDR_W{1'b0}}, r_valid};
  assign w_load    = (w_ram_cnt != '0) & (~r_valid | w_pop);

  always_ff @(posedge clk_24) begin
    if (w_wr_acc) r_mem[r_wptr] <= w_chr;
  end

  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_drop  <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + ADDR_W'(1);
      if (w_load) begin
        r_rptr  <= r_rptr + ADDR_W'(1);
        r_data  <= r_mem[r_rptr];
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
      if (w_wr_acc && !w_pop)
        r_level <= r_level + (ADDR_W+1)'(1);
      else if (!w_wr_acc && w_pop)
        r_level <= r_level - (ADDR_W+1)'(1);
      if (w_drop && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;
    end
  end

  always_ff @(posedge clk_24 or negedge rst_n) begin
    if (!rst_n) begin
      r_fstate <= FLOW_ON;
      r_pend   <= 1'b0;
      r_pbyte  <= '0;
      r_fwr    <= 1'b0;
      r_fdata  <= '0;
    end else begin
      r_fstate <= w_fstate_nx;
      r_pend   <= w_pend_nx;
      r_pbyte  <= w_pbyte_nx;
      r_fwr    <= w_fwr_nx;
      r_fdata  <= w_fdata_nx;
    end
  end

  // Issue first, then let a fresh transition load the pending slot,
  // so a transition always overrides whatever is still waiting.
  always_comb begin
    w_fstate_nx = r_fstate;
    w_pend_nx   = r_pend;
    w_pbyte_nx  = r_pbyte;
    w_fwr_nx    = 1'b0;
    w_fdata_nx  = r_fdata;
    if (r_pend && !i_tx_busy) begin
      w_fwr_nx   = 1'b1;
      w_fdata_nx = r_pbyte;
      w_pend_nx  = 1'b0;
    end
    unique case (r_fstate)
      FLOW_ON: begin
        if (r_level >= XOFF_L) begin
          w_fstate_nx = FLOW_OFF;
          w_pend_nx   = 1'b1;
          w_pbyte_nx  = XOFF_B;
        end
      end
      FLOW_OFF: begin
        if (r_level <= XON_L) begin
          w_fstate_nx = FLOW_ON;
          w_pend_nx   = 1'b1;
          w_pbyte_nx  = XON_B;
        end
      end
      default: ;
    endcase
  end

  assign o_data      = r_data;
  assign o_valid     = r_valid;
  assign o_level     = r_level;
  assign o_drop_cnt  = r_drop;
  assign o_flow_wr   = r_fwr;
  assign o_flow_data = r_fdata;

endmodule

// File: doc/rx_char_fifo.md
Name: rx_char_fifo

Overview:
Receive-side character FIFO. It sits between the rxuart byte output and the Morse timing engine.
- Sanitises incoming bytes to 7-bit upper-case ASCII and stores them.
- Presents stored characters first-word-fall-through (FWFT) with a valid/read handshake.
- Generates XON/XOFF flow-control bytes for the txuart path when occupancy crosses set thresholds, so a fast host cannot overrun the slow Morse output.

Parameters:
ADDR_W, 11, address width; depth = 2^ADDR_W entries (2048).
XOFF_LEVEL, 2016, occupancy at or above which XOFF is requested.
XON_LEVEL, 512, occupancy at or below which XON is requested after an XOFF.

Ports:
clk_24  in  1  24 MHz system clock.
rst_n  in  1  asynchronous active-low reset.
i_wr  in  1  one-cycle strobe: i_data holds a received byte.
i_data  in  8  received byte.
i_rd  in  1  consumer pop request; honoured only while o_valid=1.
o_data  out  7  head character; stable while o_valid=1 and no pop.
o_valid  out  1  head character present.
o_full  out  1  occupancy == 2^ADDR_W.
o_level  out  ADDR_W+1  current occupancy.
o_drop_cnt  out  8  overflow drops, saturating at 255.
i_tx_busy  in  1  txuart busy; a flow byte is issued only while this is 0.
o_flow_wr  out  1  one-cycle strobe to txuart.
o_flow_data  out  8  8'h13 (XOFF) or 8'h11 (XON); valid with o_flow_wr.

Behaviour:
- Reset (async assert, sync release by clk_24 edge):
  - Pointers, o_level and o_drop_cnt = 0.
  - o_valid = 0, o_full = 0, o_data = 0, o_flow_wr = 0, o_flow_data = 0.
  - Flow FSM = FLOW_ON, pending flag cleared.
  - RAM contents are not cleared.
  - Reset mid-transfer discards all contents and any pending flow byte.
- Input sanitising, applied on the i_wr cycle:
  - i_data[7]=1: discard. Not counted in o_drop_cnt.
  - 8'h61..8'h7A: subtract 8'h20 (force upper case).
  - 8'h0D or 8'h0A: store as 8'h20 (space).
  - Any other value < 8'h20, or 8'h7F: discard. Not counted.
  - Everything else: stored unchanged as 7 bits.
- Write acceptance:
  - A write is accepted when i_wr=1, the byte is storable, and o_full=0, with o_full evaluated before the edge.
  - If o_full=1, the byte is dropped and o_drop_cnt increments, saturating at 255. This applies even if a pop occurs on the same cycle.
- Read/FWFT:
  - A pop occurs when i_rd=1 and o_valid=1.
  - i_rd while o_valid=0 is ignored.
  - A byte written at edge N into an empty FIFO gives o_valid=1 and correct o_data after edge N+1 (one-cycle latency).
  - After a pop, the next entry appears on o_data after the same edge if already available; otherwise o_valid drops to 0.
- Simultaneous write and pop:
  - o_level unchanged.
  - On an empty FIFO, the pop is ignored and the write is accepted.
- Pointers and full:
  - Pointers are ADDR_W bits and wrap modulo 2^ADDR_W.
  - o_level is tracked as a separate ADDR_W+1-bit counter; o_full = (o_level == 2^ADDR_W).
- Flow FSM (states FLOW_ON, FLOW_OFF, plus a pending flag):
  - FLOW_ON -> FLOW_OFF when o_level >= XOFF_LEVEL; sets pending = XOFF.
  - FLOW_OFF -> FLOW_ON when o_level <= XON_LEVEL; sets pending = XON.
  - A pending byte is issued on the first cycle with i_tx_busy=0: o_flow_wr high for exactly one cycle, o_flow_data set the same cycle, then pending clears.
  - A new transition while a byte is still pending replaces the pending byte; at most one byte is outstanding.
  - No repeated XOFF is sent while remaining in FLOW_OFF.
  - XON is never sent without a prior XOFF.
  - Hysteresis requires XON_LEVEL < XOFF_LEVEL <= 2^ADDR_W.

Test Plan:
- Reset, then write "aZ\n" -> o_data sequence 0x41, 0x5A, 0x20. o_valid rises one edge after the first write. o_level reaches 3 (no pops).
- Write 0x07, 0x7F, 0xC1 -> o_valid stays 0, o_level = 0, o_drop_cnt = 0.
- Write 2048 'A' then one 'B' -> o_full = 1, o_level = 2048, o_drop_cnt = 1. Write 300 more -> o_drop_cnt = 255 (saturated).
- Fill to 2016 with i_tx_busy=1 for 10 cycles -> no o_flow_wr until busy falls, then a single pulse with 0x13. Pop down to 512 -> single pulse with 0x11.
- With o_level = 5, assert i_wr and i_rd together for 4 cycles -> o_level stays 5, data order preserved. On an empty FIFO, simultaneous i_wr and i_rd -> o_level = 1.
- Fill 100 entries, pulse rst_n low mid-stream asynchronously -> o_valid, o_level and o_flow_wr go 0 immediately. Post-reset writes are read back correctly across the pointer wrap.
